// File: rtl/lcd1602_responder.sv
// HD44780/LCD1602 bus responder: DDRAM, address counter, display flags and renderer read port. Define LCD1602_CGRAM_EN for CGRAM storage.
// Transfers take effect with cmd_strobe, SYNC_STAGES+1 cycles after the host's enable falls. While busy, only busy-flag reads are accepted.
module lcd1602_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int CMD_CYCLES  = 50,
  parameter int LONG_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_en,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_dat_in,
  output logic [7:0] lcd_dat_out,
  output logic       lcd_dat_oe,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [6:0] cursor_addr,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       two_line,
  output logic       busy,
  output logic       cmd_strobe,
  output logic       err_strobe
);

  localparam int MAX_CYCLES  = (LONG_CYCLES > CMD_CYCLES) ? LONG_CYCLES : CMD_CYCLES;
  localparam int CNT_W       = $clog2(MAX_CYCLES + 1);
  localparam int DDRAM_DEPTH = 80;

  typedef enum logic [0:0] {ST_RUN, ST_SWEEP} state_t;

  logic [10:0]      sync_q [SYNC_STAGES];
  logic             en_s, rs_s, rw_s;
  logic [7:0]       dat_s;
  logic             en_prev, rs_p, rw_p;
  logic [7:0]       dat_p;

  state_t           state;
  logic [6:0]       clr_idx;
  logic [CNT_W-1:0] busy_cnt;
  logic [6:0]       ac;
  logic             inc;
  logic             cg_sel;

  logic             fall, is_status, blocked, accept, is_instr, is_dwr, long_cmd, fn_dl0;
  logic             dd_we;
  logic [6:0]       dd_wa;
  logic [7:0]       dd_wd;
  logic [7:0]       ddram [DDRAM_DEPTH];
  logic [7:0]       host_q;
  logic [7:0]       cg_rd;

  function automatic logic ddram_legal(input logic [6:0] a);
    return (a < 7'h28) || ((a >= 7'h40) && (a < 7'h68));
  endfunction

  function automatic logic [6:0] ddram_idx(input logic [6:0] a);
    return (a < 7'h40) ? a : (a - 7'h40 + 7'd40);
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up,
                                         input logic cg, input logic two);
    logic [5:0] c;
    logic [6:0] n;
    c = up ? (a[5:0] + 6'd1) : (a[5:0] - 6'd1);
    if (cg) begin
      n = {1'b0, c};
    end else if (two) begin
      if (up) n = (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : (a + 7'd1);
      else    n = (a == 7'h40) ? 7'h27 : (a == 7'h00) ? 7'h67 : (a - 7'd1);
    end else begin
      if (up) n = (a == 7'h4F) ? 7'h00 : (a + 7'd1);
      else    n = (a == 7'h00) ? 7'h4F : (a - 7'd1);
    end
    return n;
  endfunction

  // All host lines share one synchronizer chain; the *_p copies hold the values seen while en was still high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      en_prev <= 1'b0;
      rs_p    <= 1'b0;
      rw_p    <= 1'b0;
      dat_p   <= 8'h00;
    end else begin
      sync_q[0] <= {lcd_en, lcd_rs, lcd_rw, lcd_dat_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      en_prev <= en_s;
      rs_p    <= rs_s;
      rw_p    <= rw_s;
      dat_p   <= dat_s;
    end
  end

  assign {en_s, rs_s, rw_s, dat_s} = sync_q[SYNC_STAGES-1];

  always_comb begin
    fall      = en_prev & ~en_s;
    is_status = ~rs_p & rw_p;
    blocked   = fall & busy & ~is_status;
    accept    = fall & ~blocked;
    is_instr  = accept & ~rs_p & ~rw_p;
    is_dwr    = accept & rs_p & ~rw_p;
    long_cmd  = is_instr & (dat_p[7:2] == 6'd0) & (dat_p[1:0] != 2'd0);
    fn_dl0    = is_instr & (dat_p[7:5] == 3'b001) & ~dat_p[4];
  end

  always_comb begin
    dd_we = 1'b0;
    dd_wa = clr_idx;
    dd_wd = 8'h20;
    if (state == ST_SWEEP) begin
      dd_we = 1'b1;
    end else if (is_dwr && !cg_sel && ddram_legal(ac)) begin
      dd_we = 1'b1;
      dd_wa = ddram_idx(ac);
      dd_wd = dat_p;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_SWEEP;
      clr_idx     <= 7'd0;
      busy_cnt    <= CNT_W'(LONG_CYCLES);
      busy        <= 1'b1;
      ac          <= 7'h00;
      inc         <= 1'b1;
      cg_sel      <= 1'b0;
      disp_on     <= 1'b0;
      cursor_on   <= 1'b0;
      blink_on    <= 1'b0;
      two_line    <= 1'b0;
      cmd_strobe  <= 1'b0;
      err_strobe  <= 1'b0;
      lcd_dat_oe  <= 1'b0;
      lcd_dat_out <= 8'h00;
    end else begin
      cmd_strobe <= accept;
      err_strobe <= blocked | fn_dl0;
      lcd_dat_oe <= en_s & rw_s;
      if (en_s && rw_s) lcd_dat_out <= rs_s ? host_q : {busy, ac};

      case (state)
        ST_SWEEP: begin
          clr_idx <= clr_idx + 7'd1;
          if (clr_idx == 7'(DDRAM_DEPTH - 1)) state <= ST_RUN;
        end
        default: clr_idx <= 7'd0;
      endcase

      if (accept && !is_status) begin
        busy     <= 1'b1;
        busy_cnt <= long_cmd ? CNT_W'(LONG_CYCLES) : CNT_W'(CMD_CYCLES);
      end else if (busy_cnt > CNT_W'(1)) begin
        busy_cnt <= busy_cnt - CNT_W'(1);
      end else begin
        busy_cnt <= '0;
        busy     <= 1'b0;
      end

      if (is_instr) begin
        casez (dat_p)
          8'b1???????: begin ac <= dat_p[6:0]; cg_sel <= 1'b0; end
          8'b01??????: begin ac <= {1'b0, dat_p[5:0]}; cg_sel <= 1'b1; end
          8'b001?????: two_line <= dat_p[3];
          8'b0001????: if (!dat_p[3]) ac <= ac_step(ac, dat_p[2], cg_sel, two_line);
          8'b00001???: {disp_on, cursor_on, blink_on} <= dat_p[2:0];
          8'b000001??: inc <= dat_p[1];
          8'b0000001?: begin ac <= 7'h00; cg_sel <= 1'b0; end
          8'b00000001: begin
            ac      <= 7'h00;
            inc     <= 1'b1;
            cg_sel  <= 1'b0;
            state   <= ST_SWEEP;
            clr_idx <= 7'd0;
          end
          default: ;
        endcase
      end else if (accept && rs_p) begin
        ac <= ac_step(ac, inc, cg_sel, two_line);
      end
    end
  end

  assign cursor_addr = ac;

  always_ff @(posedge clk) begin
    if (dd_we) ddram[dd_wa] <= dd_wd;
    rd_data <= ddram_legal(rd_addr) ? ddram[ddram_idx(rd_addr)] : 8'h00;
    host_q  <= cg_sel ? cg_rd : (ddram_legal(ac) ? ddram[ddram_idx(ac)] : 8'h00);
  end

`ifdef LCD1602_CGRAM_EN
  logic [7:0] cgram [64];
  logic       cg_we;

  assign cg_we = is_dwr & cg_sel;
  assign cg_rd = cgram[ac[5:0]];

  always_ff @(posedge clk) begin
    if (cg_we) cgram[ac[5:0]] <= dat_p;
  end
`else
  assign cg_rd = 8'h00;
`endif

endmodule
